bin2bcd_seq: RTL

Sequential double-dabble binary-to-BCD converter sitting between the switch bank and the seven-segment decoders. It converts an `IN_W`-bit binary value into `DIGITS` packed BCD digits, one bit per clock, so that each display can take its own digit. A start/busy/valid handshake governs each conversion, and the result holds until the next conversion completes.

---
 rtl/bin2bcd_pkg.sv | 17 +
 rtl/bin2bcd_seq_if.sv | 32 +++
 rtl/bin2bcd_seq_bcd_add3.sv | 13 +
 rtl/bin2bcd_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_e  : converter FSM states (IDLE, SHIFT)
//   BCD_W    : bits per BCD digit
//   BCD_NINE : digit value loaded on overflow
//   ADD3_TH  : digit threshold at or above which +3 is applied before a shift
package bin2bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_NINE = 4'h9;
  localparam logic [3:0]  ADD3_TH  = 4'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : bin2bcd_pkg

// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between a requester and bin2bcd_seq.
//   start : conversion request (requester -> converter)
//   bin   : binary operand, IN_W bits (requester -> converter)
//   busy  : conversion in progress (converter -> requester)
//   valid : one-cycle pulse when bcd/ovf/blank update (converter -> requester)
//   bcd   : packed BCD result, digit 0 in [3:0] (converter -> requester)
//   ovf   : operand exceeded 10^DIGITS-1 (converter -> requester)
//   blank : leading-zero mask, one bit per digit (converter -> requester)
interface bin2bcd_seq_if #(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned DIGITS = 6
) ();

  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, valid, bcd, ovf, blank
  );

  modport slave (
    input  start, bin,
    output busy, valid, bcd, ovf, blank
  );

endinterface : bin2bcd_seq_if

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
//   digit_i : working digit before the shift
//   digit_o : corrected digit (combinational)
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  assign digit_o = (digit_i >= ADD3_TH) ? BCD_W'(digit_i + 4'd3) : digit_i;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : bin2bcd_seq_if.slave (start/bin in; busy/valid/bcd/ovf/blank out)
// Optional feature macro BIN2BCD_BLANK_EN: when defined, blank carries a
// leading-zero mask computed at completion; otherwise blank is tied to 0.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 18,
  parameter int unsigned DIGITS = 6
) (
  input  logic          clk,
  input  logic          rstn,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned BCD_TOT = BCD_W * DIGITS;
  localparam int unsigned CNT_W   = (IN_W > 1) ? $clog2(IN_W) : 1;

  state_e               state_q;
  logic [IN_W-1:0]      sr_q;
  logic [BCD_TOT-1:0]   work_q;
  logic                 sticky_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [BCD_TOT-1:0]   bcd_q;
  logic                 ovf_q;

  logic [BCD_TOT-1:0]   adj_c;
  logic [IN_W-1:0]      sr_d;
  logic [BCD_TOT-1:0]   work_d;
  logic                 sticky_d;
  logic [BCD_TOT-1:0]   res_d;

  // Per-digit +3 correction ahead of the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (work_q[g*BCD_W +: BCD_W]),
      .digit_o (adj_c[g*BCD_W +: BCD_W])
    );
  end

  // One double-dabble iteration: shift {corrected BCD, operand} left by one;
  // the bit falling off the top digit feeds the sticky overflow.
  always_comb begin
    sr_d     = sr_q << 1;
    work_d   = {adj_c[BCD_TOT-2:0], sr_q[IN_W-1]};
    sticky_d = sticky_q | adj_c[BCD_TOT-1];
    res_d    = sticky_d ? {DIGITS{BCD_NINE}} : work_d;
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              zero_run;

  // Walk down from the top digit; digit 0 is never blanked
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run   = zero_run & (res_d[i*BCD_W +: BCD_W] == 4'd0);
      blank_d[i] = zero_run;
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif

  // Converter FSM and result registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      work_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sr_q     <= bus.bin;
            work_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CNT_W'(IN_W - 1);
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q     <= sr_d;
          work_q   <= work_d;
          sticky_q <= sticky_d;
          if (cnt_q == '0) begin
            bcd_q   <= res_d;
            ovf_q   <= sticky_d;
`ifdef BIN2BCD_BLANK_EN
            blank_q <= blank_d;
`endif
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.bcd   = bcd_q;
  assign bus.ovf   = ovf_q;

endmodule : bin2bcd_seq
